// File: rtl/multdiv_seq_if.sv
// Execute-stage bus between the pipeline and the multiply/divide sequencer.
// master: pipeline side (drives start pulses and operands, receives result).
// slave : sequencer side (samples starts when idle, returns result/exception/RDY/busy).
interface multdiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_seq.sv
// Sequential signed multiply (radix-2 shift-add) / divide (restoring) unit.
// Latency: RDY pulses WIDTH+1 edges after the start edge (1 edge for divide by zero).
// Backpressure: none queued; starts while busy are dropped, result held until next FIN.
// Ports: clock, reset (sync, active-high); bus (slave) carries ctrl_MULT/ctrl_DIV,
//   operands A/B, data_result, data_exception, data_resultRDY, busy.
module multdiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  multdiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // |A|; during divide it doubles as dividend/quotient shifter
  logic [WIDTH-1:0] b_q, b_d;        // |B|; during multiply it doubles as the product low half
  logic [WIDTH-1:0] acc_q, acc_d;    // product high half / partial remainder
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mul_q, mul_d;
  logic             sign_q, sign_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic               start;
  logic               start_dz;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   quot_signed;
  logic               mul_ovf;
  logic               div_ovf;

  assign start    = (state_q == IDLE) && (bus.ctrl_MULT || bus.ctrl_DIV);
  assign start_dz = !bus.ctrl_MULT && (bus.data_operandB == '0);
  // Two's-complement negation of the most negative value yields 2^(WIDTH-1) as an unsigned magnitude.
  assign a_mag = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign b_mag = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  assign mul_sum   = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : '0);
  assign div_trial = {acc_q, a_q[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, b_q};

  assign prod        = {acc_q, b_q};
  assign prod_signed = sign_q ? -prod : prod;
  // Negative results may reach magnitude 2^(WIDTH-1); positive ones only 2^(WIDTH-1)-1.
  assign mul_ovf = sign_q ? ((prod[2*WIDTH-1:WIDTH] != '0) ||
                             (prod[WIDTH-1] && (prod[WIDTH-2:0] != '0)))
                          : (prod[2*WIDTH-1:WIDTH-1] != '0);
  assign quot_signed = sign_q ? -a_q : a_q;
  // Only MIN / -1 produces a positive quotient of 2^(WIDTH-1).
  assign div_ovf = !sign_q && a_q[WIDTH-1];

  // State register and datapath flops
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mul_q    <= 1'b0;
      sign_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mul_q    <= mul_d;
      sign_q   <= sign_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = start_dz ? FIN : RUN;
      RUN:     if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output updates
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mul_d    = mul_q;
    sign_d   = sign_q;
    dz_d     = dz_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d    = a_mag;
          b_d    = b_mag;
          acc_d  = '0;
          cnt_d  = '0;
          mul_d  = bus.ctrl_MULT;
          sign_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
          dz_d   = start_dz;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (mul_q) begin
          // Add-then-shift: the multiplier drains out of b_q as product bits fill in.
          {acc_d, b_d} = {mul_sum, b_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
          acc_d = div_diff[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = div_trial[WIDTH-1:0];
          a_d   = {a_q[WIDTH-2:0], 1'b0};
        end
      end
      FIN: begin
        rdy_d = 1'b1;
        if (dz_q) begin
          result_d = '0;
          exc_d    = 1'b1;
        end else if (mul_q) begin
          result_d = prod_signed[WIDTH-1:0];
          exc_d    = mul_ovf;
        end else begin
          result_d = quot_signed;
          exc_d    = div_ovf;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy           = (state_q != IDLE);
    bus.data_result    = result_q;
    bus.data_exception = exc_q;
    bus.data_resultRDY = rdy_q;
  end
endmodule
